fixed_point_divider: RTL and testbench

//  Sequential signed fixed-point divider. It computes quotient = dividend / divisor in the
//  Q(N-FRAC).FRAC format that the FC datapath uses for its sequential multiplier.

---
 rtl/fixed_point_divider_if.sv | 24 ++
 rtl/fixed_point_divider.sv | 133 +++++++++++++
 tb/tb_fixed_point_divider.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fixed_point_divider_if.sv
// Handshake and operand bundle for the sequential fixed-point divider.
// The master drives the operands and control. The slave (the divider) returns the result and status.
interface fixed_point_divider_if #(
  parameter int N = 16
);
  logic         enable;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic         finish;
  logic         busy;
  logic         div_by_zero;

  modport master (
    output enable, start, dividend, divisor,
    input  quotient, finish, busy, div_by_zero
  );

  modport slave (
    input  enable, start, dividend, divisor,
    output quotient, finish, busy, div_by_zero
  );
endinterface

// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider in Q(N-FRAC).FRAC format.
// It runs a restoring shift-subtract on the operand magnitudes and produces one raw quotient bit per enabled cycle.
// Sign and saturation are applied on the last iteration.
// A zero divisor skips the run and returns the saturated value that matches the dividend's sign.
module fixed_point_divider #(
  parameter int N    = 16,
  parameter int FRAC = 10
) (
  input logic                 clk,
  input logic                 reset,
  fixed_point_divider_if.slave bus
);
  localparam int W  = N + FRAC;
  localparam int CW = $clog2(W);

  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);
  localparam logic [N-1:0]  MAX_Q    = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  MIN_Q    = {1'b1, {(N-1){1'b0}}};
  localparam logic [W-1:0]  POS_LIM  = {{(FRAC+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic [W-1:0]  NEG_LIM  = {{FRAC{1'b0}}, 1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_sign;
  logic [W-1:0]    r_num;
  logic [N-1:0]    r_den;
  logic [N:0]      r_rem;
  logic [W-1:0]    r_raw;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_quot;
  logic            r_finish;
  logic            r_busy;
  logic            r_dbz;

  logic            w_accept;
  logic            w_div_zero;
  logic            w_last;
  logic [N-1:0]    w_abs_dvd;
  logic [N-1:0]    w_abs_dvs;
  logic [N+1:0]    w_rem_shift;
  logic            w_ge;
  logic [W-1:0]    w_raw_next;
  logic [N-1:0]    w_sat;

  assign w_accept    = bus.enable && bus.start && (r_state != RUN);
  assign w_div_zero  = (bus.divisor == '0);
  assign w_last      = (r_cnt == LAST_CNT);
  assign w_abs_dvd   = bus.dividend[N-1] ? -bus.dividend : bus.dividend;
  assign w_abs_dvs   = bus.divisor[N-1]  ? -bus.divisor  : bus.divisor;
  assign w_rem_shift = {r_rem, r_num[W-1]};
  assign w_ge        = (w_rem_shift >= {2'b00, r_den});
  assign w_raw_next  = {r_raw[W-2:0], w_ge};

  assign bus.quotient    = r_quot;
  assign bus.finish      = r_finish;
  assign bus.busy        = r_busy;
  assign bus.div_by_zero = r_dbz;

  // Apply the latched sign to the raw magnitude and clamp it to the representable range.
  always_comb begin
    w_sat = '0;
    if (!r_sign) begin
      w_sat = (w_raw_next > POS_LIM) ? MAX_Q : w_raw_next[N-1:0];
    end else begin
      w_sat = (w_raw_next > NEG_LIM) ? MIN_Q : -w_raw_next[N-1:0];
    end
  end

  // Next-state logic. When enable is low, the FSM holds its current state.
  always_comb begin
    w_state_next = r_state;
    if (bus.enable) begin
      unique case (r_state)
        IDLE, DONE: if (bus.start) w_state_next = w_div_zero ? DONE : RUN;
        RUN:        if (w_last) w_state_next = DONE;
        default:    w_state_next = IDLE;
      endcase
    end
  end

  // State register. Reset has priority over everything else.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Operand capture, shift-subtract iterations and result/status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sign   <= 1'b0;
      r_num    <= '0;
      r_den    <= '0;
      r_rem    <= '0;
      r_raw    <= '0;
      r_cnt    <= '0;
      r_quot   <= '0;
      r_finish <= 1'b0;
      r_busy   <= 1'b0;
      r_dbz    <= 1'b0;
    end else if (bus.enable) begin
      if (w_accept) begin
        if (w_div_zero) begin
          r_quot   <= bus.dividend[N-1] ? MIN_Q : MAX_Q;
          r_finish <= 1'b1;
          r_dbz    <= 1'b1;
          r_busy   <= 1'b0;
        end else begin
          r_sign   <= bus.dividend[N-1] ^ bus.divisor[N-1];
          r_num    <= {w_abs_dvd, {FRAC{1'b0}}};
          r_den    <= w_abs_dvs;
          r_rem    <= '0;
          r_raw    <= '0;
          r_cnt    <= '0;
          r_finish <= 1'b0;
          r_dbz    <= 1'b0;
          r_busy   <= 1'b1;
        end
      end else if (r_state == RUN) begin
        r_num <= {r_num[W-2:0], 1'b0};
        r_rem <= w_ge ? (N+1)'(w_rem_shift - {2'b00, r_den}) : w_rem_shift[N:0];
        r_raw <= w_raw_next;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_quot   <= w_sat;
          r_finish <= 1'b1;
          r_busy   <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_fixed_point_divider.sv
// Self-checking bench for fixed_point_divider.
// The first part applies a table of known vectors.
// The second part applies random operands, checked against an integer-arithmetic reference.
// The last part covers hand-written sequences for stalls, busy-start, mid-run reset and back-to-back starts.
module tb_fixed_point_divider;
  localparam int N    = 16;
  localparam int FRAC = 10;
  localparam int LAT  = N + FRAC;

  typedef struct {
    logic signed [N-1:0] a;
    logic signed [N-1:0] b;
    longint              q;
    logic                dbz;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[9];

  fixed_point_divider_if #(.N(N)) bus ();

  fixed_point_divider #(.N(N), .FRAC(FRAC)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running clock with a 10 ns period.
  always #5 clk = ~clk;

  // Watchdog so that a stuck design still terminates the run.
  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference quotient using plain arithmetic.
  // It scales, divides with truncation toward zero, then clamps.
  function automatic longint refQuot(input longint a, input longint b);
    longint q;
    if (b == 0) return (a < 0) ? -(64'sd1 <<< (N-1)) : (64'sd1 <<< (N-1)) - 1;
    q = (a * (64'sd1 <<< FRAC)) / b;
    if (q > (64'sd1 <<< (N-1)) - 1) q = (64'sd1 <<< (N-1)) - 1;
    if (q < -(64'sd1 <<< (N-1)))    q = -(64'sd1 <<< (N-1));
    return q;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Launch one division, then wait for finish within a bounded number of edges.
  // Edges are counted after the accepting edge.
  task automatic applyStimulus(input logic signed [N-1:0] a, input logic signed [N-1:0] b,
                               output longint q, output logic dbz, output int edges);
    @(negedge clk);
    bus.enable   = 1'b1;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = N'($urandom);
    bus.divisor  = N'($urandom);
    edges = 0;
    if (b != 0) begin
      checkOutput("finish_low_after_start", longint'(bus.finish), 0);
      checkOutput("busy_after_start", longint'(bus.busy), 1);
    end
    while (!bus.finish && edges < 200) begin
      @(negedge clk);
      edges++;
    end
    if (!bus.finish) checkOutput("finish_timeout", 0, 1);
    q   = longint'($signed(bus.quotient));
    dbz = bus.div_by_zero;
  endtask

  initial begin
    longint              q;
    logic                dbz;
    int                  edges;
    logic signed [N-1:0] ra;
    logic signed [N-1:0] rb;

    vecs[0] = '{16'sd3072,  16'sd2048,  1536,   1'b0};
    vecs[1] = '{-16'sd1024, 16'sd4096,  -256,   1'b0};
    vecs[2] = '{16'sd7,     16'sd3,     2389,   1'b0};
    vecs[3] = '{-16'sd7,    16'sd3,     -2389,  1'b0};
    vecs[4] = '{16'sd30720, 16'sd512,   32767,  1'b0};
    vecs[5] = '{16'h8000,   16'sd1024,  -32768, 1'b0};
    vecs[6] = '{16'h8000,   -16'sd1024, 32767,  1'b0};
    vecs[7] = '{16'sd1024,  16'sd0,     32767,  1'b1};
    vecs[8] = '{-16'sd5,    16'sd0,     -32768, 1'b1};

    reset        = 1'b1;
    bus.enable   = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_quotient", longint'(bus.quotient), 0);
    checkOutput("reset_finish", longint'(bus.finish), 0);
    checkOutput("reset_busy", longint'(bus.busy), 0);
    checkOutput("reset_dbz", longint'(bus.div_by_zero), 0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, q, dbz, edges);
      checkOutput($sformatf("vec%0d_quotient", i), q, vecs[i].q);
      checkOutput($sformatf("vec%0d_dbz", i), longint'(dbz), longint'(vecs[i].dbz));
      checkOutput($sformatf("vec%0d_latency", i), edges, vecs[i].dbz ? 0 : LAT);
    end

    for (int i = 0; i < 40; i++) begin
      ra = N'($urandom);
      case ($urandom_range(0, 4))
        0:       rb = '0;
        1, 2:    rb = N'($urandom_range(1, 200)) * (($urandom_range(0, 1) == 1) ? -16'sd1 : 16'sd1);
        default: rb = N'($urandom);
      endcase
      applyStimulus(ra, rb, q, dbz, edges);
      checkOutput($sformatf("rand%0d_quotient(%0d/%0d)", i, ra, rb), q, refQuot(longint'(ra), longint'(rb)));
      checkOutput($sformatf("rand%0d_dbz", i), longint'(dbz), (rb == 0) ? 1 : 0);
      checkOutput($sformatf("rand%0d_latency", i), edges, (rb == 0) ? 0 : LAT);
    end

    // Stall for five cycles mid-run, then pulse start while busy; only the stall should show.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'sd3072;
    bus.divisor  = 16'sd2048;
    @(negedge clk);
    bus.start = 1'b0;
    edges = 0;
    repeat (5) begin @(negedge clk); edges++; end
    bus.enable = 1'b0;
    repeat (5) begin @(negedge clk); edges++; end
    checkOutput("stall_busy_held", longint'(bus.busy), 1);
    checkOutput("stall_finish_low", longint'(bus.finish), 0);
    bus.enable   = 1'b1;
    bus.start    = 1'b1;
    bus.dividend = 16'sd100;
    bus.divisor  = 16'sd7;
    @(negedge clk);
    edges++;
    bus.start = 1'b0;
    while (!bus.finish && edges < 200) begin @(negedge clk); edges++; end
    checkOutput("stall_latency", edges, LAT + 5);
    checkOutput("stall_quotient", longint'($signed(bus.quotient)), 1536);
    checkOutput("stall_dbz", longint'(bus.div_by_zero), 0);

    // Reset partway through a run clears everything, and no finish follows.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'sd2000;
    bus.divisor  = 16'sd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_quotient", longint'(bus.quotient), 0);
    checkOutput("midreset_finish", longint'(bus.finish), 0);
    checkOutput("midreset_busy", longint'(bus.busy), 0);
    checkOutput("midreset_dbz", longint'(bus.div_by_zero), 0);
    reset = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    checkOutput("midreset_no_finish", longint'(bus.finish), 0);

    // Fresh operation after the abort, then back-to-back starts from DONE.
    applyStimulus(-16'sd7, 16'sd3, q, dbz, edges);
    checkOutput("post_reset_quotient", q, -2389);
    checkOutput("post_reset_latency", edges, LAT);
    applyStimulus(-16'sd1024, 16'sd4096, q, dbz, edges);
    checkOutput("b2b_quotient", q, -256);
    checkOutput("b2b_latency", edges, LAT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
